// File: rtl/io_handshake_pkg.sv
// Shared encodings for the I/O handshake sequencer: FSM states and request kinds.
package io_handshake_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ARM        = 2'd1,
        WAIT_PRESS = 2'd2,
        FIRE       = 2'd3
    } state_t;

    typedef enum logic {
        KIND_CONFIRM = 1'b0,
        KIND_PAUSE   = 1'b1
    } kind_t;

endpackage

// File: rtl/io_handshake_sequencer_button_debouncer.sv
// Front-panel button conditioning: a multi-flop synchroniser followed by a
// stability counter. The debounced level changes only after the synchronised
// input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module button_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic [CNT_W-1:0]       count;
    logic                   sync;

    assign sync = sync_ff[SYNC_STAGES-1];

    // Shift the asynchronous button through the synchroniser chain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw};
        end
    end

    // Count consecutive disagreeing cycles; accept the new level at the limit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            level <= 1'b0;
        end else if (sync == level) begin
            count <= '0;
        end else if (count == CNT_MAX) begin
            level <= sync;
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/io_handshake_sequencer.sv
// Operator handshake for OUTPUT/INPUT/PAUSE instructions: waits for a fresh
// debounced press of the selected button and emits one single-cycle pulse.
module io_handshake_sequencer
    import io_handshake_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic is_input,
    input  logic is_output,
    input  logic raw_confirm,
    input  logic raw_continue,
    output logic confirmation,
    output logic continue_pulse,
    output logic waiting_for_user
);

    state_t state, state_next;
    kind_t  kind, kind_q, kind_next;
    logic   req;
    logic   abort;
    logic   confirm_level;
    logic   continue_level;
    logic   sel_level;

    button_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_confirm_db (
        .clock(clock),
        .reset(reset),
        .raw  (raw_confirm),
        .level(confirm_level)
    );

    button_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_continue_db (
        .clock(clock),
        .reset(reset),
        .raw  (raw_continue),
        .level(continue_level)
    );

    assign req       = is_input | is_output;
    assign kind      = (is_input & is_output) ? KIND_PAUSE : KIND_CONFIRM;
    assign abort     = !req || (kind != kind_q);
    assign sel_level = (kind_q == KIND_PAUSE) ? continue_level : confirm_level;

    // State and latched request kind.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            kind_q <= KIND_CONFIRM;
        end else begin
            state  <= state_next;
            kind_q <= kind_next;
        end
    end

    // Next state: arm on a request, require a release before accepting a press.
    always_comb begin
        state_next = state;
        kind_next  = kind_q;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = ARM;
                    kind_next  = kind;
                end
            end
            ARM: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (!sel_level) begin
                    state_next = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (sel_level) begin
                    state_next = FIRE;
                end
            end
            FIRE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign confirmation     = (state == FIRE) && (kind_q == KIND_CONFIRM);
    assign continue_pulse   = (state == FIRE) && (kind_q == KIND_PAUSE);
    assign waiting_for_user = (state == ARM) || (state == WAIT_PRESS);

endmodule

// File: tb/tb_io_handshake_sequencer.sv
// Directed bench for io_handshake_sequencer with a short debounce window.
module tb_io_handshake_sequencer;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int CNT_W           = 4;

    typedef struct {
        logic ii;
        logic io;
        logic rc;
        logic rn;
        logic conf;
        logic cont;
        logic wt;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic is_input = 1'b0;
    logic is_output = 1'b0;
    logic raw_confirm = 1'b0;
    logic raw_continue = 1'b0;
    logic confirmation;
    logic continue_pulse;
    logic waiting_for_user;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    io_handshake_sequencer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .is_input        (is_input),
        .is_output       (is_output),
        .raw_confirm     (raw_confirm),
        .raw_continue    (raw_continue),
        .confirmation    (confirmation),
        .continue_pulse  (continue_pulse),
        .waiting_for_user(waiting_for_user)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic ii, input logic io, input logic rc, input logic rn);
        is_input     = ii;
        is_output    = io;
        raw_confirm  = rc;
        raw_continue = rn;
    endtask

    task automatic checkOutput(input string name, input logic ec, input logic en, input logic ew);
        checks++;
        if (confirmation !== ec || continue_pulse !== en || waiting_for_user !== ew) begin
            errors++;
            $display("[TB] FAIL %s: got conf=%b cont=%b wait=%b, expected conf=%b cont=%b wait=%b",
                     name, confirmation, continue_pulse, waiting_for_user, ec, en, ew);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic pushVec(input logic ii, input logic io, input logic rc, input logic rn,
                           input logic conf, input logic cont, input logic wt);
        vec_t v;
        v.ii = ii; v.io = io; v.rc = rc; v.rn = rn;
        v.conf = conf; v.cont = cont; v.wt = wt;
        vecs.push_back(v);
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 0);
        #2 reset = 1'b0;
        #1 checkOutput("reset_async", 0, 0, 0);
        repeat (2) tick();
        reset = 1'b1;
        checkOutput("reset_state", 0, 0, 0);
    endtask

    task automatic runCount(input int n, input logic ii, input logic io, input logic rc,
                            input logic rn, output int nconf, output int ncont);
        nconf = 0;
        ncont = 0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(ii, io, rc, rn);
            tick();
            if (confirmation === 1'b1) nconf++;
            if (continue_pulse === 1'b1) ncont++;
        end
    endtask

    initial begin
        int nconf;
        int ncont;

        // Clean OUTPUT press followed by a second OUTPUT with the button still held.
        for (int i = 0; i < 8; i++)   pushVec(0, 1, 0, 0, 0, 0, 1);
        for (int i = 8; i < 14; i++)  pushVec(0, 1, 1, 0, 0, 0, 1);
        pushVec(0, 1, 1, 0, 1, 0, 0);
        pushVec(0, 1, 1, 0, 0, 0, 0);
        pushVec(0, 1, 1, 0, 0, 0, 1);
        pushVec(0, 1, 1, 0, 0, 0, 1);
        for (int i = 18; i < 24; i++) pushVec(0, 1, 0, 0, 0, 0, 1);
        for (int i = 24; i < 30; i++) pushVec(0, 1, 1, 0, 0, 0, 1);
        pushVec(0, 1, 1, 0, 1, 0, 0);
        pushVec(0, 1, 1, 0, 0, 0, 0);
        pushVec(0, 0, 0, 0, 0, 0, 0);

        #1;
        doReset();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ii, vecs[i].io, vecs[i].rc, vecs[i].rn);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].conf, vecs[i].cont, vecs[i].wt);
        end

        // Bouncing confirm never fires; the final stable rise fires once.
        doReset();
        runCount(3, 0, 1, 0, 0, nconf, ncont);
        checkOutput("t2_armed", 0, 0, 1);
        nconf = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, ((i / 2) % 2 == 0), 0);
            tick();
            if (confirmation === 1'b1 || continue_pulse === 1'b1) nconf++;
        end
        checkCount("t2_bounce_pulses", nconf, 0);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(0, 1, 1, 0);
            tick();
            checkOutput($sformatf("t2_k%0d", k), (k == 7), 0, !(k == 7 || k == 8));
        end

        // PAUSE ignores confirm and completes on continue.
        doReset();
        runCount(14, 1, 1, 1, 0, nconf, ncont);
        checkCount("t4_confirm_ignored", nconf + ncont, 0);
        checkOutput("t4_waiting", 0, 0, 1);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1, 1, 0, 1);
            tick();
            checkOutput($sformatf("t4_k%0d", k), 0, (k == 7), !(k == 7 || k == 8));
        end

        // Dropping the request before the debounced rise aborts; re-arm completes.
        doReset();
        runCount(3, 0, 1, 0, 0, nconf, ncont);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(0, (k != 3), 1, 0);
            tick();
            if (k == 3) begin
                checkOutput("t5_abort", 0, 0, 0);
            end else begin
                checkOutput($sformatf("t5_k%0d", k), (k == 7), 0, !(k == 3 || k == 7 || k == 8));
            end
        end

        // Reset mid-WAIT_PRESS and during FIRE clears outputs asynchronously.
        doReset();
        runCount(3, 0, 1, 0, 0, nconf, ncont);
        checkOutput("t6_wait", 0, 0, 1);
        runCount(2, 0, 1, 1, 0, nconf, ncont);
        #3 reset = 1'b0;
        #1 checkOutput("t6_async_wait", 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        repeat (2) tick();
        reset = 1'b1;
        runCount(8, 0, 1, 0, 0, nconf, ncont);
        checkCount("t6_no_pulse_after_release", nconf + ncont, 0);
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(0, 1, 1, 0);
            tick();
            checkOutput($sformatf("t6_k%0d", k), (k == 7), 0, (k != 7));
        end
        #3 reset = 1'b0;
        #1 checkOutput("t6_async_fire", 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        repeat (2) tick();
        reset = 1'b1;
        runCount(12, 0, 1, 0, 0, nconf, ncont);
        checkCount("t6_idle_after_fire_reset", nconf + ncont, 0);
        checkOutput("t6_rearmed", 0, 0, 1);
        runCount(10, 0, 1, 1, 0, nconf, ncont);
        checkCount("t6_fresh_press_conf", nconf, 1);
        checkCount("t6_fresh_press_cont", ncont, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
